// File: rtl/uart_tx_sequencer_pkg.sv
// uart_tx_sequencer_pkg: shared types and constants for the UART transmit path.
// UART_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_tx_sequencer_pkg;
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
`endif
   typedef logic [3:0] uart_bit_count_t;
   typedef logic bit_t;
   localparam bit_t UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: frame data shift register with serial tap and running parity.
// UART_TX_PARITY_EN exposes the parity of the latched byte.
module uart_tx_shifter #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              ser_out,
   output logic              nxt_out
`ifdef UART_TX_PARITY_EN
   ,
   output logic              parity
`endif
);
   logic [DATA_W-1:0] sh;
   always_ff @(posedge clk or posedge reset)
      if (reset) sh <= '0;
      else if (load) sh <= din;
      else if (shift) sh <= sh >> 1;
   assign ser_out = sh[0];
   assign nxt_out = sh[1];
`ifdef UART_TX_PARITY_EN
   // par holds bits already shifted out; the bit still at sh[0] completes it
   logic par;
   always_ff @(posedge clk or posedge reset)
      if (reset) par <= 1'b0;
      else if (load) par <= 1'b0;
      else if (shift) par <= par ^ sh[0];
   assign parity = par ^ sh[0];
`endif
endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: UART transmit FSM driving an external bit timer and the TX line.
// UART_TX_PARITY_EN inserts a parity bit (PARITY_ODD selects odd parity).
module uart_tx_sequencer
   import uart_tx_sequencer_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic              tx_abort,
   input  logic              bit_tick,
   output logic              timer_clear,
   output logic              tx_line,
   output logic              tx_busy,
   output logic              tx_done
);
   localparam int CNT_W = $clog2(DATA_W);
   uart_tx_state_t   state;
   logic [CNT_W-1:0] bit_cnt;
   logic             stop_cnt;
   logic             tick, last_bit, load, shift, ser_out, nxt_out;
`ifdef UART_TX_PARITY_EN
   logic             parity;
`endif
   // a tick landing on the restart cycle belongs to the previous bit
   assign tick     = bit_tick && !timer_clear;
   assign last_bit = bit_cnt == CNT_W'(DATA_W - 1);
   assign load     = state == IDLE && tx_valid && tx_ready;
   assign shift    = state == DATA && tick && !tx_abort && !last_bit;

   uart_tx_shifter #(.DATA_W(DATA_W)) u_shifter (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .shift  (shift),
      .din    (tx_data),
      .ser_out(ser_out),
      .nxt_out(nxt_out)
`ifdef UART_TX_PARITY_EN
      ,
      .parity (parity)
`endif
   );

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= IDLE;
         tx_line     <= UART_IDLE_LEVEL;
         tx_ready    <= 1'b1;
         tx_busy     <= 1'b0;
         timer_clear <= 1'b0;
         tx_done     <= 1'b0;
         bit_cnt     <= '0;
         stop_cnt    <= 1'b0;
      end else begin
         timer_clear <= 1'b0;
         tx_done     <= 1'b0;
         if (tx_abort && state != IDLE) begin
            state    <= IDLE;
            tx_line  <= UART_IDLE_LEVEL;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
         end else
            case (state)
               IDLE: if (load) begin
                  state       <= START;
                  tx_line     <= 1'b0;
                  timer_clear <= 1'b1;
                  tx_ready    <= 1'b0;
                  tx_busy     <= 1'b1;
               end
               START: if (tick) begin
                  state       <= DATA;
                  bit_cnt     <= '0;
                  tx_line     <= ser_out;
                  timer_clear <= 1'b1;
               end
               DATA: if (tick) begin
                  timer_clear <= 1'b1;
                  if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                     state   <= PARITY;
                     tx_line <= parity ^ PARITY_ODD;
`else
                     state    <= STOP;
                     tx_line  <= UART_IDLE_LEVEL;
                     stop_cnt <= 1'b0;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx_line <= nxt_out;
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: if (tick) begin
                  state       <= STOP;
                  tx_line     <= UART_IDLE_LEVEL;
                  stop_cnt    <= 1'b0;
                  timer_clear <= 1'b1;
               end
`endif
               STOP: if (tick) begin
                  if (stop_cnt == 1'(STOP_BITS - 1)) begin
                     state    <= IDLE;
                     tx_done  <= 1'b1;
                     tx_ready <= 1'b1;
                     tx_busy  <= 1'b0;
                  end else begin
                     stop_cnt    <= stop_cnt + 1'b1;
                     timer_clear <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: directed plus randomized frame checks against a bit-list model.
// Instance 0 uses one stop bit, instance 1 two stop bits (and odd parity under UART_TX_PARITY_EN).
module tb_uart_tx_sequencer;
   typedef logic bq_t[$];
   logic clk = 1'b0, reset = 1'b1, sel = 1'b0;
   logic tx_valid = 1'b0, tx_abort = 1'b0, bit_tick = 1'b0;
   logic [7:0] tx_data = '0;
   logic [1:0] rdy, clr, line, busy, done;
   int vectors = 0, miscompares = 0;

   always #5 clk = ~clk;

   uart_tx_sequencer #(.DATA_W(8), .STOP_BITS(1)
`ifdef UART_TX_PARITY_EN
      , .PARITY_ODD(1'b0)
`endif
   ) u0 (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid & ~sel),
      .tx_ready(rdy[0]), .tx_abort(tx_abort & ~sel), .bit_tick(bit_tick & ~sel),
      .timer_clear(clr[0]), .tx_line(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));

   uart_tx_sequencer #(.DATA_W(8), .STOP_BITS(2)
`ifdef UART_TX_PARITY_EN
      , .PARITY_ODD(1'b1)
`endif
   ) u1 (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid & sel),
      .tx_ready(rdy[1]), .tx_abort(tx_abort & sel), .bit_tick(bit_tick & sel),
      .timer_clear(clr[1]), .tx_line(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));

   // {line, timer_clear, ready, busy, done} of the selected instance
   function automatic logic [4:0] st();
      return {line[sel], clr[sel], rdy[sel], busy[sel], done[sel]};
   endfunction

   // expected line level for each bit period of a frame
   function automatic bq_t frame_bits(input logic [7:0] d, input logic s);
      bq_t q;
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
      q.push_back(^d ^ s);
`endif
      for (int i = 0; i < (s ? 2 : 1); i++) q.push_back(1'b1);
      return q;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ab = bit index at which to abort (-1 for none); hold keeps tx_valid high with nd
   task automatic frame(input logic [7:0] d, input int p, input int ab, input bit hold,
                        input logic [7:0] nd);
      bq_t q = frame_bits(d, sel);
      int ak = $urandom_range(0, p - 1);
      tx_data  = d;
      tx_valid = 1'b1;
      chk("accept_ready", {7'b0, rdy[sel]}, 8'd1);
      for (int b = 0; b < q.size(); b++)
         for (int k = 0; k < p; k++) begin
            @(negedge clk);
            if (b == 0 && k == 0) begin
               tx_valid = hold;
               tx_data  = hold ? nd : 8'($urandom);
            end
            chk($sformatf("s%0d_bit%0d_cyc%0d", sel, b, k), {3'b0, st()},
                {3'b0, q[b], k == 0, 1'b0, 1'b1, 1'b0});
            bit_tick = (k == p - 1) || (k == 0 && $urandom_range(0, 1) == 1);
            if (b == ab && k == ak) begin
               tx_abort = 1'b1;
               @(negedge clk);
               tx_abort = 1'b0;
               bit_tick = 1'b0;
               chk("abort", {3'b0, st()}, 8'b10100);
               return;
            end
         end
      @(negedge clk);
      bit_tick = 1'b0;
      chk($sformatf("s%0d_done", sel), {3'b0, st()}, 8'b10101);
      if (!hold) tx_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         chk("reset_state", {3'b0, st()}, 8'b10100);
      end
      reset = 1'b0;
      sel   = 1'b0;
      @(negedge clk);
      frame(8'hA5, 4, -1, 0, 8'h00);
      sel = 1'b1;
      frame(8'h00, 4, -1, 0, 8'h00);
      frame(8'h07, 3, -1, 0, 8'h00);
      sel = 1'b0;
      frame(8'h3C, 4, 4, 0, 8'h00);
      // tick and abort while idle must not start anything
      bit_tick = 1'b1;
      tx_abort = 1'b1;
      @(negedge clk);
      bit_tick = 1'b0;
      tx_abort = 1'b0;
      chk("idle_ignore", {3'b0, st()}, 8'b10100);
      // asynchronous reset during START
      tx_data  = 8'h96;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("start_entry", {3'b0, st()}, 8'b01010);
      #2 reset = 1'b1;
      #1 chk("async_reset", {3'b0, st()}, 8'b10100);
      @(negedge clk);
      reset = 1'b0;
      chk("post_reset_idle", {3'b0, st()}, 8'b10100);
      frame(8'h96, 3, -1, 0, 8'h00);
      frame(8'h55, 4, -1, 1, 8'hAA);
      frame(8'hAA, 4, -1, 0, 8'h00);
      repeat (16) begin
         sel = 1'($urandom_range(0, 1));
         frame(8'($urandom), $urandom_range(2, 5),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1, 0, 8'h00);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
